// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types for the I2S ADC receive path
// Purpose: default sample width, sample/stereo types and receiver FSM state encoding.
// Ports: none (package).
package audio_pkg;

  localparam int DEF_DATA_W = 16;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } rx_state_e;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-bit synchroniser with rising-edge pulse on bit 0
// Purpose: brings WIDTH asynchronous inputs into clk through STAGES flops and
//          flags a 0->1 transition of the synchronised bit 0.
// Ports: clk, rst_n (async active-low), d[WIDTH] raw inputs,
//        q[WIDTH] synchronised outputs, rise one-clk pulse for q[0] rising.
module sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic                         prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1][0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1][0] & ~prev_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// rtl/i2s_adc_rx.sv - I2S ADC deserialiser with one-entry stereo output register
// Purpose: samples adcdat/adclrc on synchronised bclk rising edges, assembles
//          left/right words and presents them as a valid/ready stereo pair.
// Optional: I2S_RX_MONO_EN adds sample_m = (L + R) >>> 1, registered with the pair.
// Ports: clk, rst_n (async active-low), en receive enable, bclk/adclrc/adcdat codec
//        serial inputs, sample_l/sample_r/valid/ready output handshake,
//        sample_m (optional) mono mix, overflow sticky overwrite flag.
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              bclk,
  input  logic              adclrc,
  input  logic              adcdat,
  output logic [DATA_W-1:0] sample_l,
  output logic [DATA_W-1:0] sample_r,
  output logic              valid,
  input  logic              ready,
`ifdef I2S_RX_MONO_EN
  output logic [DATA_W-1:0] sample_m,
`endif
  output logic              overflow
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [2:0] sync_q;
  logic       rise;
  logic       lrc_sync, dat_sync;

  sync_edge #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (3)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({adcdat, adclrc, bclk}),
    .q     (sync_q),
    .rise  (rise)
  );

  assign lrc_sync = sync_q[1];
  assign dat_sync = sync_q[2];

  rx_state_e         state_q, state_d;
  logic              ch_q, ch_d;             // 0 = left, 1 = right
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] sr_q, sr_d;             // previous bits of the word in flight
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic              left_ok_q, left_ok_d;   // left_hold belongs to the current pair
  logic              lrc_q, lrc_d;           // lrc captured on the last rise
  logic [DATA_W-1:0] out_l_q, out_l_d;
  logic [DATA_W-1:0] out_r_q, out_r_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              frame_edge, load;
  logic [DATA_W-1:0] word;

  assign frame_edge = rise && (lrc_sync != lrc_q);
  assign word       = {sr_q, dat_sync};

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    lrc_d       = lrc_q;
    load        = 1'b0;

    if (rise) begin
      lrc_d = lrc_sync;
    end

    case (state_q)
      IDLE: begin
        // Pairing always begins on a left slot; right edges are ignored here.
        if (frame_edge && !lrc_sync) begin
          state_d   = SHIFT;
          ch_d      = 1'b0;
          cnt_d     = '0;
          left_ok_d = 1'b0;
        end
      end
      SHIFT: begin
        if (frame_edge) begin
          // Short frame: drop the word in flight and restart on the new slot.
          ch_d  = lrc_sync;
          cnt_d = '0;
          if (!lrc_sync) begin
            left_ok_d = 1'b0;
          end
        end else if (rise) begin
          sr_d  = word[DATA_W-2:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = WAIT;
            if (!ch_q) begin
              left_hold_d = word;
              left_ok_d   = 1'b1;
            end else begin
              load      = left_ok_q;
              left_ok_d = 1'b0;
            end
          end
        end
      end
      WAIT: begin
        if (frame_edge) begin
          state_d = SHIFT;
          ch_d    = lrc_sync;
          cnt_d   = '0;
          if (!lrc_sync) begin
            left_ok_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      load    = 1'b0;
    end
  end

  always_comb begin
    out_l_d    = out_l_q;
    out_r_d    = out_r_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      out_l_d = left_hold_q;
      out_r_d = word;
      valid_d = 1'b1;
      if (valid_q && !ready) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      lrc_q       <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      lrc_q       <= lrc_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sample_l = out_l_q;
  assign sample_r = out_r_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

`ifdef I2S_RX_MONO_EN
  logic [DATA_W:0]   mono_sum;
  logic [DATA_W-1:0] mono_q, mono_d;

  // Sign-extended sum; dropping bit 0 is an arithmetic shift (floor division by 2).
  assign mono_sum = {left_hold_q[DATA_W-1], left_hold_q} + {word[DATA_W-1], word};

  always_comb begin
    mono_d = mono_q;
    if (load) begin
      mono_d = DATA_W'(mono_sum >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mono_q <= '0;
    end else begin
      mono_q <= mono_d;
    end
  end

  assign sample_m = mono_q;
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb/tb_i2s_adc_rx.sv - directed-vector bench for i2s_adc_rx
module tb_i2s_adc_rx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         bclk = 1'b0;
  logic         adclrc = 1'b1;
  logic         adcdat = 1'b0;
  logic [W-1:0] sample_l, sample_r;
  logic         valid;
  logic         ready = 1'b1;
  logic         overflow;
`ifdef I2S_RX_MONO_EN
  logic [W-1:0] sample_m;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int vcyc   = 0;
  int xfers  = 0;
  logic [W-1:0] last_l = '0, last_r = '0;
  int vcyc0, xfers0;

  i2s_adc_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bclk     (bclk),
    .adclrc   (adclrc),
    .adcdat   (adcdat),
    .sample_l (sample_l),
    .sample_r (sample_r),
    .valid    (valid),
    .ready    (ready),
`ifdef I2S_RX_MONO_EN
    .sample_m (sample_m),
`endif
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Transfer monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid) vcyc++;
    if (valid && ready) begin
      xfers++;
      last_l = sample_l;
      last_r = sample_r;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One lrc level of len bclk rises: rise 0 is the delay bit, then the word
  // MSB first, then junk ones.
  task automatic send_slot(input logic lrc, input logic [W-1:0] w, input int len);
    for (int i = 0; i < len; i++) begin
      bclk   = 1'b0;
      adclrc = lrc;
      if (i == 0)      adcdat = 1'b0;
      else if (i <= W) adcdat = w[W-i];
      else             adcdat = 1'b1;
      tick(4);
      bclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int len);
    send_slot(1'b0, l, len);
    send_slot(1'b1, r, len);
    tick(12);
  endtask

  initial begin
    tick(3);
    check_vec("rst_sample_l", 32'(sample_l), 32'h0);
    check_vec("rst_sample_r", 32'(sample_r), 32'h0);
    check_vec("rst_valid",    32'(valid),    32'h0);
    check_vec("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    tick(2);
    send_slot(1'b1, 16'h0000, 4);

    // Basic pair with ready held high: one-cycle valid pulse.
    vcyc0 = vcyc; xfers0 = xfers;
    send_frame(16'h8001, 16'h7FFE, 18);
    check_vec("t1_vcyc",  32'(vcyc - vcyc0),   32'd1);
    check_vec("t1_xfers", 32'(xfers - xfers0), 32'd1);
    check_vec("t1_l",     32'(last_l),         32'h8001);
    check_vec("t1_r",     32'(last_r),         32'h7FFE);

    // Stream picked up in the middle of a right slot.
    en = 1'b0; tick(2); en = 1'b1;
    vcyc0 = vcyc; xfers0 = xfers;
    send_slot(1'b1, 16'hFFFF, 8);
    send_frame(16'h1234, 16'h5678, 18);
    check_vec("t2_xfers", 32'(xfers - xfers0), 32'd1);
    check_vec("t2_l",     32'(last_l),         32'h1234);
    check_vec("t2_r",     32'(last_r),         32'h5678);

    // Overwrite while stalled.
    ready = 1'b0;
    xfers0 = xfers;
    send_frame(16'h0001, 16'h0002, 18);
    check_vec("t3a_valid", 32'(valid), 32'h1);
    check_vec("t3a_ovf",   32'(overflow), 32'h0);
    send_frame(16'h0003, 16'h0004, 18);
    check_vec("t3b_l",     32'(sample_l), 32'h0003);
    check_vec("t3b_r",     32'(sample_r), 32'h0004);
    check_vec("t3b_valid", 32'(valid),    32'h1);
    check_vec("t3b_ovf",   32'(overflow), 32'h1);
    ready = 1'b1;
    tick(4);
    check_vec("t3c_xfers", 32'(xfers - xfers0), 32'd1);
    check_vec("t3c_l",     32'(last_l),   32'h0003);
    check_vec("t3c_r",     32'(last_r),   32'h0004);
    check_vec("t3c_valid", 32'(valid),    32'h0);
    check_vec("t3c_ovf",   32'(overflow), 32'h1);

    // 32-bit slots with junk ones after the word.
    xfers0 = xfers;
    send_frame(16'hABCD, 16'hABCD, 33);
    check_vec("t4_xfers", 32'(xfers - xfers0), 32'd1);
    check_vec("t4_l",     32'(last_l),         32'hABCD);
    check_vec("t4_r",     32'(last_r),         32'hABCD);

    // Reset in the middle of a right word.
    send_slot(1'b0, 16'h1111, 18);
    send_slot(1'b1, 16'hFFFF, 9);
    rst_n = 1'b0;
    tick(2);
    check_vec("t5_rst_l",     32'(sample_l), 32'h0);
    check_vec("t5_rst_r",     32'(sample_r), 32'h0);
    check_vec("t5_rst_valid", 32'(valid),    32'h0);
    check_vec("t5_rst_ovf",   32'(overflow), 32'h0);
    rst_n = 1'b1;
    tick(2);
    xfers0 = xfers;
    send_frame(16'h00FF, 16'hFF00, 18);
    check_vec("t5_xfers", 32'(xfers - xfers0), 32'd1);
    check_vec("t5_l",     32'(last_l),         32'h00FF);
    check_vec("t5_r",     32'(last_r),         32'hFF00);
    check_vec("t5_ovf",   32'(overflow),       32'h0);

`ifdef I2S_RX_MONO_EN
    ready = 1'b0;
    send_frame(16'h7FFF, 16'h0001, 18);
    check_vec("mono_pos", 32'(sample_m), 32'h4000);
    ready = 1'b1; tick(2); ready = 1'b0;
    send_frame(16'h8000, 16'hFFFF, 18);
    check_vec("mono_neg", 32'(sample_m), 32'hBFFF);
    ready = 1'b1; tick(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
